// File: rtl/alu_mon_pkg.sv
// Shared definitions for the ALU activity monitor.
//   - WIN_LEN_DEF / CNT_W_DEF : default window length and accumulator width
//   - NUM_OPS                 : number of opcodes tracked (4-bit opcode space)
//   - mon_state_e             : monitor FSM states
package alu_mon_pkg;

   localparam int unsigned WIN_LEN_DEF = 1024;
   localparam int unsigned CNT_W_DEF   = 24;
   localparam int unsigned NUM_OPS     = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2,
      ST_DUMP  = 2'd3
   } mon_state_e;

endpackage

// File: rtl/popcount16.sv
// Combinational population count of a 16-bit word.
//   data_i  : word to count
//   count_o : number of set bits, 0..16
module popcount16 (
   input  logic [15:0] data_i,
   output logic [4:0]  count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < 16; i++) begin
         count_o = count_o + {4'b0000, data_i[i]};
      end
   end

endmodule

// File: rtl/alu_activity_monitor.sv
// Measures switching activity on the alu16_lp result bus over a fixed
// window and reports, per opcode, the accumulated yout bit toggles and the
// number of enabled cycles, then streams the 16-entry table out through a
// valid/ready port.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle request to start a window (IDLE only)
//   yout, s, en         : ALU result, the opcode that produced it, update flag
//   busy                : high while a window is armed, counting or dumping
//   rd_valid, rd_ready  : dump handshake
//   rd_opcode           : table index of the presented entry
//   rd_toggles          : saturating toggle total for rd_opcode
//   rd_samples          : saturating enabled-cycle count for rd_opcode
//   done                : one-cycle pulse after the last entry is accepted
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; table keeps the last window's results
// ST_ARM   | one cycle: clear table, capture prev_y, reset window count
// ST_COUNT | WIN_LEN cycles of toggle accumulation
// ST_DUMP  | present entries 0..15, advance on rd_valid & rd_ready
module alu_activity_monitor
   import alu_mon_pkg::*;
#(
   parameter int unsigned WIN_LEN = WIN_LEN_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      yout,
   input  logic [3:0]       s,
   input  logic             en,
   output logic             busy,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [3:0]       rd_opcode,
   output logic [CNT_W-1:0] rd_toggles,
   output logic [15:0]      rd_samples,
   output logic             done
);

   localparam logic [15:0] WIN_LAST = 16'(WIN_LEN - 1);

   mon_state_e       state_q, state_d;
   logic [15:0]      prev_y_q;
   logic [15:0]      win_cnt_q;
   logic [3:0]       idx_q;
   logic             done_q;
   logic [CNT_W-1:0] acc_q [NUM_OPS];
   logic [15:0]      cnt_q [NUM_OPS];

   logic [4:0]       toggles;
   logic [CNT_W:0]   acc_sum;
   logic [CNT_W-1:0] acc_d;
   logic [15:0]      cnt_d;
   logic             win_last;
   logic             accept;
   logic             last_accept;

   popcount16 u_popcount (
      .data_i  (yout ^ prev_y_q),
      .count_o (toggles)
   );

   assign win_last    = (win_cnt_q == WIN_LAST);
   assign accept      = (state_q == ST_DUMP) && rd_ready;
   assign last_accept = accept && (idx_q == 4'hF);

   // Extra carry bit catches overflow so the accumulator clamps instead of wrapping.
   always_comb begin
      acc_sum = {1'b0, acc_q[s]} + {{(CNT_W - 4){1'b0}}, toggles};
      acc_d   = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
      cnt_d   = (cnt_q[s] == 16'hFFFF) ? cnt_q[s] : cnt_q[s] + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)       state_d = ST_ARM;
         ST_ARM:                    state_d = ST_COUNT;
         ST_COUNT: if (win_last)    state_d = ST_DUMP;
         ST_DUMP:  if (last_accept) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_y_q  <= '0;
         win_cnt_q <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
         for (int i = 0; i < NUM_OPS; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         done_q <= last_accept;
         case (state_q)
            ST_ARM: begin
               prev_y_q  <= yout;
               win_cnt_q <= '0;
               idx_q     <= '0;
               for (int i = 0; i < NUM_OPS; i++) begin
                  acc_q[i] <= '0;
                  cnt_q[i] <= '0;
               end
            end
            ST_COUNT: begin
               // prev_y tracks the bus every cycle so gated cycles still set the baseline.
               prev_y_q  <= yout;
               win_cnt_q <= win_cnt_q + 16'd1;
               if (en) begin
                  acc_q[s] <= acc_d;
                  cnt_q[s] <= cnt_d;
               end
            end
            ST_DUMP: begin
               // Wraps back to 0 after entry 15, ready for the next window.
               if (accept) idx_q <= idx_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign rd_valid   = (state_q == ST_DUMP);
   assign rd_opcode  = rd_valid ? idx_q        : '0;
   assign rd_toggles = rd_valid ? acc_q[idx_q] : '0;
   assign rd_samples = rd_valid ? cnt_q[idx_q] : '0;
   assign done       = done_q;

endmodule

// File: tb/tb_alu_activity_monitor.sv
module tb_alu_activity_monitor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        start2;
   logic [15:0] yout;
   logic [3:0]  s;
   logic        en;
   logic        rd_ready;

   logic        busy1, rd_valid1, done1;
   logic [3:0]  rd_opcode1;
   logic [23:0] rd_toggles1;
   logic [15:0] rd_samples1;

   logic        busy2, rd_valid2, done2;
   logic [3:0]  rd_opcode2;
   logic [7:0]  rd_toggles2;
   logic [15:0] rd_samples2;

   logic        sel;
   logic        o_busy, o_valid, o_done;
   logic [3:0]  o_op;
   logic [23:0] o_tog;
   logic [15:0] o_smp;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_activity_monitor #(.WIN_LEN(8), .CNT_W(24)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .yout(yout), .s(s), .en(en),
      .busy(busy1), .rd_valid(rd_valid1), .rd_ready(rd_ready),
      .rd_opcode(rd_opcode1), .rd_toggles(rd_toggles1),
      .rd_samples(rd_samples1), .done(done1)
   );

   alu_activity_monitor #(.WIN_LEN(20), .CNT_W(8)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2), .yout(yout), .s(s), .en(en),
      .busy(busy2), .rd_valid(rd_valid2), .rd_ready(rd_ready),
      .rd_opcode(rd_opcode2), .rd_toggles(rd_toggles2),
      .rd_samples(rd_samples2), .done(done2)
   );

   assign o_busy  = sel ? busy2     : busy1;
   assign o_valid = sel ? rd_valid2 : rd_valid1;
   assign o_done  = sel ? done2     : done1;
   assign o_op    = sel ? rd_opcode2 : rd_opcode1;
   assign o_tog   = sel ? {16'h0000, rd_toggles2} : rd_toggles1;
   assign o_smp   = sel ? rd_samples2 : rd_samples1;

   // Pulse start, let ARM capture y_b as prev, then run n COUNT cycles with
   // yout alternating y_a, y_b, y_a, ...  Returns at the negedge where the
   // DUT has just finished its n-th COUNT cycle.
   task automatic run_window(input bit which, input logic [3:0] s_v, input logic en_v,
                             input logic [15:0] y_a, input logic [15:0] y_b, input int n);
      @(negedge clk);
      if (which) start2 = 1'b1; else start = 1'b1;
      yout = y_b; s = s_v; en = en_v;
      @(negedge clk);
      start = 1'b0; start2 = 1'b0;
      total++;
      if (o_busy !== 1'b1) begin
         bad++; $display("FAIL arm_busy: got %b expected 1", o_busy);
      end
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
         total++;
         if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
            bad++; $display("FAIL count_flags cyc %0d: busy=%b valid=%b expected 1/0", i, o_busy, o_valid);
         end
         yout = (i % 2 == 0) ? y_a : y_b;
         @(negedge clk);
      end
   endtask

   // Walk all 16 entries; only entry op carries data. Optionally stall at
   // stall_idx for stall_cyc cycles while holding start high (must be ignored).
   task automatic check_dump(input int stall_idx, input int stall_cyc, input logic [3:0] op,
                             input logic [23:0] exp_tog, input logic [15:0] exp_smp);
      logic [23:0] et;
      logic [15:0] es;
      for (int i = 0; i < 16; i++) begin
         et = (i == int'(op)) ? exp_tog : 24'h0;
         es = (i == int'(op)) ? exp_smp : 16'h0;
         if (i == stall_idx) begin
            rd_ready = 1'b0;
            start = 1'b1; start2 = 1'b1;
            for (int k = 0; k < stall_cyc; k++) begin
               total++;
               if (o_valid !== 1'b1 || o_op !== 4'(i) || o_tog !== et || o_smp !== es) begin
                  bad++;
                  $display("FAIL stall entry %0d cyc %0d: got v=%b op=%0d tog=%0d smp=%0d expected 1/%0d/%0d/%0d",
                           i, k, o_valid, o_op, o_tog, o_smp, i, et, es);
               end
               @(negedge clk);
            end
            start = 1'b0; start2 = 1'b0;
         end
         total++;
         if (o_valid !== 1'b1 || o_op !== 4'(i) || o_tog !== et || o_smp !== es || o_done !== 1'b0) begin
            bad++;
            $display("FAIL dump entry %0d: got v=%b op=%0d tog=%0d smp=%0d done=%b expected 1/%0d/%0d/%0d/0",
                     i, o_valid, o_op, o_tog, o_smp, o_done, i, et, es);
         end
         rd_ready = 1'b1;
         @(negedge clk);
      end
      rd_ready = 1'b0;
      total++;
      if (o_done !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_op !== 4'h0 ||
          o_tog !== 24'h0 || o_smp !== 16'h0) begin
         bad++;
         $display("FAIL done_cycle: got done=%b valid=%b busy=%b op=%0d tog=%0d smp=%0d expected 1/0/0/0/0/0",
                  o_done, o_valid, o_busy, o_op, o_tog, o_smp);
      end
      @(negedge clk);
      total++;
      if (o_done !== 1'b0) begin
         bad++; $display("FAIL done_width: got %b expected 0", o_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; yout = '0; s = '0; en = 1'b0;
      rd_ready = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy1, rd_valid1, done1} !== 3'b000 || rd_opcode1 !== 4'h0 ||
          rd_toggles1 !== 24'h0 || rd_samples1 !== 16'h0) begin
         bad++; $display("FAIL reset_dut: got busy/valid/done=%b%b%b op=%0d tog=%0d smp=%0d expected all 0",
                         busy1, rd_valid1, done1, rd_opcode1, rd_toggles1, rd_samples1);
      end
      total++;
      if ({busy2, rd_valid2, done2} !== 3'b000 || rd_opcode2 !== 4'h0 ||
          rd_toggles2 !== 8'h0 || rd_samples2 !== 16'h0) begin
         bad++; $display("FAIL reset_dut_sat: got busy/valid/done=%b%b%b op=%0d tog=%0d smp=%0d expected all 0",
                         busy2, rd_valid2, done2, rd_opcode2, rd_toggles2, rd_samples2);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (busy1 !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset: got busy=%b expected 0", busy1);
      end
   endtask

   task automatic test_alternating();
      sel = 1'b0;
      run_window(1'b0, 4'd3, 1'b1, 16'hFFFF, 16'h0000, 8);
      check_dump(16, 0, 4'd3, 24'd128, 16'd8);
   endtask

   task automatic test_gated();
      sel = 1'b0;
      run_window(1'b0, 4'd6, 1'b0, 16'h0001, 16'h0000, 8);
      check_dump(16, 0, 4'd6, 24'd0, 16'd0);
   endtask

   task automatic test_saturation();
      sel = 1'b1;
      run_window(1'b1, 4'd5, 1'b1, 16'hFFFF, 16'h0000, 20);
      check_dump(16, 0, 4'd5, 24'd255, 16'd20);
      sel = 1'b0;
   endtask

   task automatic test_back_pressure();
      sel = 1'b0;
      run_window(1'b0, 4'd2, 1'b1, 16'h0F0F, 16'h0000, 8);
      check_dump(2, 5, 4'd2, 24'd64, 16'd8);
   endtask

   task automatic test_reset_mid();
      sel = 1'b0;
      run_window(1'b0, 4'd4, 1'b1, 16'hFFFF, 16'h0000, 4);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (busy1 !== 1'b0 || rd_valid1 !== 1'b0 || done1 !== 1'b0) begin
         bad++; $display("FAIL mid_reset_async: got busy=%b valid=%b done=%b expected 0/0/0",
                         busy1, rd_valid1, done1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         total++;
         if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            bad++; $display("FAIL mid_reset_quiet cyc %0d: got done=%b busy=%b expected 0/0", k, done1, busy1);
         end
         @(negedge clk);
      end
      run_window(1'b0, 4'd9, 1'b1, 16'h0003, 16'h0000, 8);
      check_dump(16, 0, 4'd9, 24'd16, 16'd8);
   endtask

   initial begin
      test_reset();
      test_alternating();
      test_gated();
      test_saturation();
      test_back_pressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
